ram_io_responder: RTL and testbench
===================================

Name: ram_io_responder

Overview:
- Responder end of the byte-serial memory bus driven by the memory controller.
- Contains a byte-addressed RAM with 1-cycle registered read latency.
- Decodes an IO window at 0x30000–0x30007:
  - UART TX byte FIFO with a full/backpressure flag.
  - UART RX byte FIFO.
  - Simulation-halt register.
- Sits between the CPU's memory controller and the board/testbench UART.

Parameters:
- ADDR_WIDTH, 17: RAM index width (RAM holds 2^ADDR_WIDTH bytes).
- TX_DEPTH, 8: TX FIFO depth in bytes (power of two, ≥4).
- RX_DEPTH, 8: RX FIFO depth in bytes (power of two, ≥2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes all state
- write_or_read  in  1  1 = write, 0 = read
- addr  in  32  byte address from controller
- data_in  in  8  write byte from controller
- data_out  out  8  read byte to controller (registered)
- uart_full  out  1  TX FIFO almost-full backpressure to controller
- tx_data  out  8  head byte of TX FIFO
- tx_valid  out  1  TX FIFO non-empty
- tx_ready  in  1  UART sink accepts tx_data this cycle
- rx_data  in  8  incoming UART byte
- rx_valid  in  1  rx_data valid this cycle
- sim_end  out  1  sticky halt flag
- tx_overflow  out  1  sticky: a TX push was dropped

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
  - Reset values: data_out=0, uart_full=0, tx_valid=0, tx_data=0, sim_end=0, tx_overflow=0. Both FIFOs empty (pointers and counts = 0).
  - RAM contents are not reset.
  - A write presented in the reset cycle is ignored.
- rdy=0 (rst=0): no state changes at all.
  - RAM, FIFOs, data_out and flags hold; tx_ready and rx_valid are ignored that cycle.
- Address decode:
  - io_sel = (addr[17:16]==2'b11).
  - Otherwise RAM at index addr[ADDR_WIDTH-1:0]; upper bits are ignored (wrap).
- RAM write: write_or_read=1 and !io_sel → mem[idx] <= data_in at the posedge.
- RAM read: write_or_read=0 and !io_sel → data_out <= mem[idx] at the posedge.
  - Read-before-write: data_out never reflects a same-cycle write.
  - Latency is exactly 1 cycle: address in cycle t gives the byte on data_out in cycle t+1. The controller issues consecutive addresses back-to-back.
- Write in IO space (addr[2:0] selects the register):
  - 0x30000: push data_in into the TX FIFO.
  - 0x30004: set sim_end=1 (sticky until rst).
  - Other offsets: ignored.
- Read in IO space:
  - 0x30000: data_out <= RX head and pop the RX FIFO. If the RX FIFO is empty: data_out <= 0, no pop.
  - 0x30004: data_out <= {6'b0, rx_nonempty, tx_empty}.
  - Other offsets: data_out <= 0.
- TX FIFO:
  - tx_valid = count≠0; tx_data = head (combinational from storage).
  - Pop when tx_valid && tx_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance. This is legal even when full.
  - Push when full and no pop: byte dropped, tx_overflow <= 1 (sticky).
  - Pointers wrap modulo TX_DEPTH. The count needs log2(TX_DEPTH)+1 bits.
- uart_full: registered; the next-cycle value is (next_count ≥ TX_DEPTH-2).
  - The 2-entry slack covers the controller's in-flight request.
  - Deasserts as soon as next_count < TX_DEPTH-2.
- RX FIFO:
  - Push rx_data when rx_valid.
  - Push when full: byte dropped silently, unless a controller pop of 0x30000 happens in the same cycle, in which case both occur.
- No other outputs; all bus responses follow the fixed 1-cycle latency. There is no handshake on the controller side beyond uart_full.

Test Plan:
- Reset, then write bytes 0x11,0x22,0x33,0x44 to 0x100..0x103 on consecutive cycles, then read 0x100..0x103 back-to-back → data_out shows 0x11,0x22,0x33,0x44 on the cycles following each address. Reading 0x20100 returns 0x11 (wrap).
- Same-cycle write 0x5A and read of 0x200 (old value 0x00), then read again → first data_out=0x00, second=0x5A.
- tx_ready=0; write 0x41..0x48 to 0x30000 → uart_full rises after the 6th push. The 9th push sets tx_overflow=1. Then tx_ready=1 → tx_data sequence 0x41..0x48, tx_valid falls after 8 pops, and uart_full clears once count<6.
- tx_ready=1 with a simultaneous push every cycle → count stays 1, tx_data streams in order, no overflow.
- Drive rx bytes 0x61,0x62; read 0x30004 → 0x02. Read 0x30000 three times → 0x61, 0x62, 0x00.
- Write 0x30004 → sim_end=1 next cycle and held. Assert rdy=0 during a RAM write → memory unchanged. Pulse rst mid-stream → FIFOs empty, uart_full=0, sim_end=0.

Source files
------------

// File: rtl/ram_io_responder.sv
// Responder end of the byte-serial memory bus: byte RAM with 1-cycle read latency
// plus an IO window holding UART TX/RX FIFOs and a sticky simulation-halt flag.
module ram_io_responder #(
   parameter int ADDR_WIDTH = 17,
   parameter int TX_DEPTH   = 8,
   parameter int RX_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        write_or_read,
   input  logic [31:0] addr,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        uart_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        sim_end,
   output logic        tx_overflow
);
   localparam int TXW = $clog2(TX_DEPTH);
   localparam int RXW = $clog2(RX_DEPTH);
   localparam logic [TXW:0] C_TX_FULL = (TXW+1)'(TX_DEPTH);
   localparam logic [TXW:0] C_TX_HIGH = (TXW+1)'(TX_DEPTH - 2);
   localparam logic [RXW:0] C_RX_FULL = (RXW+1)'(RX_DEPTH);

   logic [7:0]     r_mem [0:(1 << ADDR_WIDTH) - 1];
   logic [7:0]     r_tx_mem [0:TX_DEPTH-1];
   logic [7:0]     r_rx_mem [0:RX_DEPTH-1];
   logic [TXW-1:0] r_tx_rd, r_tx_wr;
   logic [TXW:0]   r_tx_cnt;
   logic [RXW-1:0] r_rx_rd, r_rx_wr;
   logic [RXW:0]   r_rx_cnt;
   logic [7:0]     r_data_out;
   logic           r_uart_full, r_sim_end, r_tx_overflow;

   logic               w_en, w_io_sel, w_off0, w_off4;
   logic               w_tx_push_req, w_tx_push, w_tx_pop, w_tx_full;
   logic               w_rx_pop, w_rx_push, w_rx_nonempty, w_rx_full;
   logic [TXW:0]       w_tx_cnt_nxt;
   logic [RXW:0]       w_rx_cnt_nxt;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic               w_unused_addr;

   assign w_en          = rdy & ~rst;
   assign w_io_sel      = (addr[17:16] == 2'b11);
   assign w_off0        = (addr[2:0] == 3'd0);
   assign w_off4        = (addr[2:0] == 3'd4);
   assign w_idx         = addr[ADDR_WIDTH-1:0];
   assign w_unused_addr = ^addr[31:18];

   assign w_tx_full     = (r_tx_cnt == C_TX_FULL);
   assign tx_valid      = (r_tx_cnt != {(TXW+1){1'b0}});
   assign tx_data       = tx_valid ? r_tx_mem[r_tx_rd] : 8'h00;
   assign w_tx_pop      = w_en & tx_valid & tx_ready;
   assign w_tx_push_req = w_en & write_or_read & w_io_sel & w_off0;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_tx_push     = w_tx_push_req & (~w_tx_full | w_tx_pop);

   assign w_rx_nonempty = (r_rx_cnt != {(RXW+1){1'b0}});
   assign w_rx_full     = (r_rx_cnt == C_RX_FULL);
   assign w_rx_pop      = w_en & ~write_or_read & w_io_sel & w_off0 & w_rx_nonempty;
   assign w_rx_push     = w_en & rx_valid & (~w_rx_full | w_rx_pop);

   always_comb begin
      w_tx_cnt_nxt = r_tx_cnt;
      case ({w_tx_push, w_tx_pop})
         2'b10:   w_tx_cnt_nxt = r_tx_cnt + (TXW+1)'(1);
         2'b01:   w_tx_cnt_nxt = r_tx_cnt - (TXW+1)'(1);
         default: w_tx_cnt_nxt = r_tx_cnt;
      endcase
   end

   always_comb begin
      w_rx_cnt_nxt = r_rx_cnt;
      case ({w_rx_push, w_rx_pop})
         2'b10:   w_rx_cnt_nxt = r_rx_cnt + (RXW+1)'(1);
         2'b01:   w_rx_cnt_nxt = r_rx_cnt - (RXW+1)'(1);
         default: w_rx_cnt_nxt = r_rx_cnt;
      endcase
   end

   // Storage arrays carry no reset; only pointers and counts define FIFO state.
   always_ff @(posedge clk) begin
      if (w_en & write_or_read & ~w_io_sel) r_mem[w_idx] <= data_in;
      if (w_tx_push) r_tx_mem[r_tx_wr] <= data_in;
      if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_rd       <= '0;
         r_tx_wr       <= '0;
         r_tx_cnt      <= '0;
         r_rx_rd       <= '0;
         r_rx_wr       <= '0;
         r_rx_cnt      <= '0;
         r_data_out    <= 8'h00;
         r_uart_full   <= 1'b0;
         r_sim_end     <= 1'b0;
         r_tx_overflow <= 1'b0;
      end else if (rdy) begin
         if (w_tx_push) r_tx_wr <= r_tx_wr + TXW'(1);
         if (w_tx_pop)  r_tx_rd <= r_tx_rd + TXW'(1);
         if (w_rx_push) r_rx_wr <= r_rx_wr + RXW'(1);
         if (w_rx_pop)  r_rx_rd <= r_rx_rd + RXW'(1);
         r_tx_cnt    <= w_tx_cnt_nxt;
         r_rx_cnt    <= w_rx_cnt_nxt;
         r_uart_full <= (w_tx_cnt_nxt >= C_TX_HIGH);
         if (w_tx_push_req & w_tx_full & ~w_tx_pop) r_tx_overflow <= 1'b1;
         if (write_or_read & w_io_sel & w_off4) r_sim_end <= 1'b1;
         if (!write_or_read) begin
            if (!w_io_sel) begin
               r_data_out <= r_mem[w_idx];
            end else begin
               case (addr[2:0])
                  3'd0:    r_data_out <= w_rx_nonempty ? r_rx_mem[r_rx_rd] : 8'h00;
                  3'd4:    r_data_out <= {6'b000000, w_rx_nonempty, ~tx_valid};
                  default: r_data_out <= 8'h00;
               endcase
            end
         end
      end
   end

   assign data_out    = r_data_out;
   assign uart_full   = r_uart_full;
   assign sim_end     = r_sim_end;
   assign tx_overflow = r_tx_overflow;
endmodule

// File: tb/tb_ram_io_responder.sv
// Directed self-checking bench for ram_io_responder: RAM, TX/RX FIFOs, halt flag, rdy and reset.
module tb_ram_io_responder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        write_or_read = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [7:0]  data_in = 8'h00;
   logic [7:0]  data_out;
   logic        uart_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        sim_end;
   logic        tx_overflow;

   int n_checks = 0;
   int n_errors = 0;

   ram_io_responder dut (
      .clk(clk), .rst(rst), .rdy(rdy), .write_or_read(write_or_read), .addr(addr),
      .data_in(data_in), .data_out(data_out), .uart_full(uart_full), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .sim_end(sim_end), .tx_overflow(tx_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic wr, input logic [31:0] a, input logic [7:0] d);
      write_or_read = wr;
      addr          = a;
      data_in       = d;
   endtask

   task automatic idle();
      bus(1'b0, 32'h0, 8'h00);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_data_out"}, data_out, 32'h00);
      check({tag, "_uart_full"}, uart_full, 32'h0);
      check({tag, "_tx_valid"}, tx_valid, 32'h0);
      check({tag, "_tx_data"}, tx_data, 32'h00);
      check({tag, "_sim_end"}, sim_end, 32'h0);
      check({tag, "_tx_overflow"}, tx_overflow, 32'h0);
   endtask

   initial begin
      logic [7:0] wr_bytes [4];
      wr_bytes[0] = 8'h11; wr_bytes[1] = 8'h22; wr_bytes[2] = 8'h33; wr_bytes[3] = 8'h44;

      tick(); tick();
      check_reset_state("reset");
      rst = 1'b0;

      // RAM write then back-to-back reads, 1-cycle latency
      for (int i = 0; i < 4; i++) begin
         bus(1'b1, 32'h100 + 32'(i), wr_bytes[i]);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         bus(1'b0, 32'h100 + 32'(i), 8'h00);
         tick();
         check($sformatf("ram_rd%0d", i), data_out, 32'(wr_bytes[i]));
      end
      bus(1'b0, 32'h20100, 8'h00); tick();
      check("ram_wrap", data_out, 32'h11);

      // Old value first, write does not disturb data_out, then new value
      bus(1'b1, 32'h200, 8'h00); tick();
      bus(1'b0, 32'h200, 8'h00); tick();
      check("rbw_old", data_out, 32'h00);
      bus(1'b1, 32'h200, 8'h5A); tick();
      check("rbw_hold", data_out, 32'h00);
      bus(1'b0, 32'h200, 8'h00); tick();
      check("rbw_new", data_out, 32'h5A);

      // TX fill with sink stalled
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus(1'b1, 32'h30000, 8'h41 + 8'(i)); tick();
         check($sformatf("fill_full%0d", i), uart_full, (i + 1 >= 6) ? 32'h1 : 32'h0);
         check($sformatf("fill_valid%0d", i), tx_valid, 32'h1);
      end
      check("pre_ovf", tx_overflow, 32'h0);
      bus(1'b1, 32'h30000, 8'h49); tick();
      check("ovf", tx_overflow, 32'h1);
      check("ovf_head", tx_data, 32'h41);
      idle();
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_data%0d", i), tx_data, 32'h41 + 32'(i));
         tick();
         check($sformatf("drain_full%0d", i), uart_full, (7 - i >= 6) ? 32'h1 : 32'h0);
      end
      check("drain_empty", tx_valid, 32'h0);
      check("ovf_sticky", tx_overflow, 32'h1);

      // Reset clears overflow; then streaming push+pop every cycle
      rst = 1'b1; tick(); rst = 1'b0;
      check("ovf_cleared", tx_overflow, 32'h0);
      bus(1'b1, 32'h30000, 8'h80); tick();
      for (int i = 1; i < 6; i++) begin
         check($sformatf("stream_data%0d", i), tx_data, 32'h80 + 32'(i - 1));
         bus(1'b1, 32'h30000, 8'h80 + 8'(i)); tick();
         check($sformatf("stream_valid%0d", i), tx_valid, 32'h1);
         check($sformatf("stream_full%0d", i), uart_full, 32'h0);
      end
      idle();
      check("stream_last", tx_data, 32'h85);
      tick();
      check("stream_empty", tx_valid, 32'h0);
      check("stream_no_ovf", tx_overflow, 32'h0);

      // RX path and status register
      rx_valid = 1'b1; rx_data = 8'h61; tick();
      rx_data = 8'h62; tick();
      rx_valid = 1'b0;
      tx_ready = 1'b0;
      bus(1'b1, 32'h30000, 8'h99); tick();
      bus(1'b0, 32'h30004, 8'h00); tick();
      check("status_rx_txbusy", data_out, 32'h02);
      bus(1'b0, 32'h30000, 8'h00); tick();
      check("rx0", data_out, 32'h61);
      tick();
      check("rx1", data_out, 32'h62);
      tick();
      check("rx_empty", data_out, 32'h00);
      bus(1'b0, 32'h30004, 8'h00); tick();
      check("status_none", data_out, 32'h00);
      tx_ready = 1'b1; idle(); tick();
      bus(1'b0, 32'h30004, 8'h00); tick();
      check("status_txempty", data_out, 32'h01);
      bus(1'b0, 32'h30002, 8'h00); tick();
      check("io_other", data_out, 32'h00);

      // Halt flag
      check("sim_end_pre", sim_end, 32'h0);
      bus(1'b1, 32'h30004, 8'h00); tick();
      check("sim_end_set", sim_end, 32'h1);
      idle(); tick(); tick();
      check("sim_end_hold", sim_end, 32'h1);

      // rdy=0 freezes RAM and data_out
      bus(1'b1, 32'h300, 8'h77); tick();
      bus(1'b0, 32'h300, 8'h00); tick();
      check("rdy_base", data_out, 32'h77);
      bus(1'b0, 32'h100, 8'h00); rdy = 1'b0; tick();
      check("rdy_hold_dout", data_out, 32'h77);
      bus(1'b1, 32'h300, 8'h99); tick();
      rdy = 1'b1;
      bus(1'b0, 32'h300, 8'h00); tick();
      check("rdy_ram_kept", data_out, 32'h77);

      // Mid-stream reset with a write presented during reset
      tx_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus(1'b1, 32'h30000, 8'hC0 + 8'(i)); tick();
      end
      check("mid_full", uart_full, 32'h1);
      rst = 1'b1;
      bus(1'b1, 32'h300, 8'h55); tick();
      rst = 1'b0;
      check_reset_state("midrst");
      bus(1'b0, 32'h300, 8'h00); tick();
      check("rst_write_ignored", data_out, 32'h77);
      bus(1'b0, 32'h30004, 8'h00); tick();
      check("midrst_status", data_out, 32'h01);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
